// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encoding, operand-forwarding select codes and a saturating counter helper.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_FLUSH    = 2'b10
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Operand forwarding select for one EX-stage source register.
// MEM-stage result wins over WB-stage result; register 0 is never forwarded.
module hazard_fwd_sel #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] ex_rs_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_we_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic              wb_we_i,
  output logic [1:0]        fwd_o
);
  import hazard_pkg::*;

  // Priority compare: MEM first, then WB, else the register file.
  always_comb begin
    fwd_o = FWD_RF;
    if (mem_we_i && (mem_rd_i != {REG_AW{1'b0}}) && (ex_rs_i == mem_rd_i)) begin
      fwd_o = FWD_MEM;
    end else if (wb_we_i && (wb_rd_i != {REG_AW{1'b0}}) && (ex_rs_i == wb_rd_i)) begin
      fwd_o = FWD_WB;
    end else begin
      fwd_o = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall,
// taken-branch flush (optionally multi-cycle), data-memory wait stall with
// a sticky watchdog, and a saturating stall-cycle counter.
// Stall/flush outputs are combinational from state and inputs.
module hazard_ctrl #(
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_we,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_we,
  input  logic              br_taken,
  input  logic              mem_req,
  input  logic              mem_ack,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_w,
  output logic              mem_timeout_err,
  output logic [15:0]       stall_cnt
);
  import hazard_pkg::*;

  localparam int              WCW          = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0]  TIMEOUT_V    = WCW'(MEM_TIMEOUT);
  localparam logic [WCW-1:0]  TIMEOUT_LAST = WCW'(MEM_TIMEOUT - 1);
  // Flush cycles still owed after the branch cycle itself.
  localparam logic [1:0]      FLUSH_EXTRA  = 2'(FLUSH_CYCLES - 1);

  state_e          state_q, state_d;
  logic [1:0]      flush_cnt_q, flush_cnt_d;
  logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
  logic            err_q, err_d;
  logic [15:0]     stall_cnt_q, stall_cnt_d;

  logic [1:0]      fwd_a_s, fwd_b_s;
  logic            load_use_s;
  logic            mem_block_s;

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .ex_rs_i  (ex_rs1),
    .mem_rd_i (mem_rd),
    .mem_we_i (mem_we),
    .wb_rd_i  (wb_rd),
    .wb_we_i  (wb_we),
    .fwd_o    (fwd_a_s)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .ex_rs_i  (ex_rs2),
    .mem_rd_i (mem_rd),
    .mem_we_i (mem_we),
    .wb_rd_i  (wb_rd),
    .wb_we_i  (wb_we),
    .fwd_o    (fwd_b_s)
  );

  // Forwarding is forced to the register file while in reset.
  assign fwd_a = reset ? FWD_RF : fwd_a_s;
  assign fwd_b = reset ? FWD_RF : fwd_b_s;

  assign load_use_s  = ex_is_load && ex_we && (ex_rd != {REG_AW{1'b0}}) &&
                       ((id_rs1 == ex_rd) || (id_rs2 == ex_rd));
  assign mem_block_s = mem_req && !mem_ack;

  assign mem_timeout_err = err_q;
  assign stall_cnt       = stall_cnt_q;

  // Stall/flush decode and next-state for FSM, flush count, watchdog and stall counter.
  always_comb begin
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    stall_m     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    flush_w     = 1'b0;
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    err_d       = err_q;

    if (reset) begin
      // Bubble every stage register; no holds.
      flush_d = 1'b1;
      flush_e = 1'b1;
      flush_w = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mem_block_s) begin
            stall_f    = 1'b1;
            stall_d    = 1'b1;
            stall_e    = 1'b1;
            stall_m    = 1'b1;
            flush_w    = 1'b1;
            wait_cnt_d = {WCW{1'b0}};
            state_d    = ST_MEM_WAIT;
          end else if (br_taken) begin
            flush_d     = 1'b1;
            flush_e     = 1'b1;
            flush_cnt_d = FLUSH_EXTRA;
            state_d     = (FLUSH_EXTRA != 2'd0) ? ST_FLUSH : ST_RUN;
          end else if (load_use_s) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end

        ST_FLUSH: begin
          if (mem_block_s) begin
            // Flush count is frozen and resumed after the wait.
            stall_f    = 1'b1;
            stall_d    = 1'b1;
            stall_e    = 1'b1;
            stall_m    = 1'b1;
            flush_w    = 1'b1;
            wait_cnt_d = {WCW{1'b0}};
            state_d    = ST_MEM_WAIT;
          end else begin
            flush_d = 1'b1;
            if (load_use_s) begin
              stall_f = 1'b1;
              stall_d = 1'b1;
              flush_e = 1'b1;
            end else begin
              flush_e = 1'b0;
            end
            if (flush_cnt_q <= 2'd1) begin
              flush_cnt_d = 2'd0;
              state_d     = ST_RUN;
            end else begin
              flush_cnt_d = flush_cnt_q - 2'd1;
            end
          end
        end

        ST_MEM_WAIT: begin
          if (mem_ack) begin
            // Ack cycle: stalls released, normal hazard evaluation.
            if (flush_cnt_q != 2'd0) begin
              state_d = ST_FLUSH;
              if (load_use_s) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
              end else begin
                flush_e = 1'b0;
              end
            end else if (br_taken) begin
              flush_d     = 1'b1;
              flush_e     = 1'b1;
              flush_cnt_d = FLUSH_EXTRA;
              state_d     = (FLUSH_EXTRA != 2'd0) ? ST_FLUSH : ST_RUN;
            end else if (load_use_s) begin
              stall_f = 1'b1;
              stall_d = 1'b1;
              flush_e = 1'b1;
              state_d = ST_RUN;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
            if (wait_cnt_q != TIMEOUT_V) begin
              wait_cnt_d = wait_cnt_q + {{(WCW-1){1'b0}}, 1'b1};
            end else begin
              wait_cnt_d = wait_cnt_q;
            end
            if (wait_cnt_q == TIMEOUT_LAST) begin
              err_d = 1'b1;
            end else begin
              err_d = err_q;
            end
          end
        end

        default: begin
          state_d     = ST_RUN;
          flush_cnt_d = 2'd0;
        end
      endcase
    end

    stall_cnt_d = stall_f ? sat_inc16(stall_cnt_q) : stall_cnt_q;
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= 2'd0;
      wait_cnt_q  <= {WCW{1'b0}};
      err_q       <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl built with FLUSH_CYCLES=3, MEM_TIMEOUT=8.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_hazard_ctrl;

  localparam int AW = 5;

  // ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}
  localparam logic [6:0] CTL_IDLE = 7'b0000000;
  localparam logic [6:0] CTL_RST  = 7'b0000111;
  localparam logic [6:0] CTL_LU   = 7'b1100010;
  localparam logic [6:0] CTL_BR   = 7'b0000110;
  localparam logic [6:0] CTL_FL   = 7'b0000100;
  localparam logic [6:0] CTL_FLU  = 7'b1100110;
  localparam logic [6:0] CTL_MEM  = 7'b1111001;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic          ex_we, ex_is_load, mem_we, wb_we, br_taken, mem_req, mem_ack;
  logic [1:0]    fwd_a, fwd_b;
  logic          stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
  logic          mem_timeout_err;
  logic [15:0]   stall_cnt;
  logic [6:0]    ctl;

  int            n_test = 0;
  int            n_fail = 0;
  logic [15:0]   exp_stall = 16'd0;

  assign ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w};

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(AW), .FLUSH_CYCLES(3), .MEM_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_we(ex_we), .ex_is_load(ex_is_load),
    .mem_rd(mem_rd), .mem_we(mem_we),
    .wb_rd(wb_rd), .wb_we(wb_we),
    .br_taken(br_taken), .mem_req(mem_req), .mem_ack(mem_ack),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .mem_timeout_err(mem_timeout_err), .stall_cnt(stall_cnt)
  );

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rs1 = 5'd0; ex_rs2 = 5'd0; ex_rd = 5'd0;
    mem_rd = 5'd0; wb_rd = 5'd0; ex_we = 1'b0; ex_is_load = 1'b0;
    mem_we = 1'b0; wb_we = 1'b0; br_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic set_load_use();
    ex_is_load = 1'b1; ex_we = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    ex_rs1 = 5'd3; mem_rd = 5'd3; mem_we = 1'b1; mem_req = 1'b1;
    @(negedge clk); #1;
    n_test++;
    if (ctl !== CTL_RST) begin $display("FAIL reset_ctl got=%b want=%b", ctl, CTL_RST); n_fail++; end
    n_test++;
    if (fwd_a !== 2'b00) begin $display("FAIL reset_fwd_a got=%b want=00", fwd_a); n_fail++; end
    @(negedge clk); #1;
    n_test++;
    if (stall_cnt !== 16'd0 || mem_timeout_err !== 1'b0) begin
      $display("FAIL reset_cnt_err got=%0d/%b want=0/0", stall_cnt, mem_timeout_err); n_fail++;
    end
    @(negedge clk);
    reset = 1'b0; mem_req = 1'b0;
    #1;
    n_test++;
    if (ctl !== CTL_IDLE) begin $display("FAIL post_reset_ctl got=%b want=%b", ctl, CTL_IDLE); n_fail++; end
    n_test++;
    if (fwd_a !== 2'b10) begin $display("FAIL post_reset_fwd_a got=%b want=10", fwd_a); n_fail++; end
    exp_stall = 16'd0;
  endtask

  task automatic test_forward();
    @(negedge clk);
    idle_inputs();
    ex_rs1 = 5'd3; mem_rd = 5'd3; mem_we = 1'b1; wb_rd = 5'd3; wb_we = 1'b1;
    #1;
    n_test++;
    if (fwd_a !== 2'b10) begin $display("FAIL fwd_a_double got=%b want=10", fwd_a); n_fail++; end
    mem_we = 1'b0; #1;
    n_test++;
    if (fwd_a !== 2'b01) begin $display("FAIL fwd_a_wb got=%b want=01", fwd_a); n_fail++; end
    mem_we = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0; #1;
    n_test++;
    if (fwd_a !== 2'b00) begin $display("FAIL fwd_a_rd0 got=%b want=00", fwd_a); n_fail++; end
    ex_rs1 = 5'd0; #1;
    n_test++;
    if (fwd_a !== 2'b00) begin $display("FAIL fwd_a_x0 got=%b want=00", fwd_a); n_fail++; end
    ex_rs2 = 5'd7; mem_rd = 5'd3; wb_rd = 5'd7; #1;
    n_test++;
    if (fwd_b !== 2'b01) begin $display("FAIL fwd_b_wb got=%b want=01", fwd_b); n_fail++; end
    mem_rd = 5'd7; #1;
    n_test++;
    if (fwd_b !== 2'b10) begin $display("FAIL fwd_b_mem got=%b want=10", fwd_b); n_fail++; end
    n_test++;
    if (ctl !== CTL_IDLE) begin $display("FAIL fwd_no_hazard got=%b want=%b", ctl, CTL_IDLE); n_fail++; end
  endtask

  task automatic test_load_use();
    @(negedge clk); idle_inputs(); set_load_use(); #1;
    n_test++;
    if (ctl !== CTL_LU) begin $display("FAIL lu_rs2 got=%b want=%b", ctl, CTL_LU); n_fail++; end
    exp_stall = exp_stall + 16'd1;
    @(negedge clk); id_rs2 = 5'd0; id_rs1 = 5'd5; #1;
    n_test++;
    if (ctl !== CTL_LU) begin $display("FAIL lu_back_to_back got=%b want=%b", ctl, CTL_LU); n_fail++; end
    exp_stall = exp_stall + 16'd1;
    @(negedge clk); ex_rd = 5'd0; id_rs1 = 5'd0; #1;
    n_test++;
    if (ctl !== CTL_IDLE) begin $display("FAIL lu_rd0 got=%b want=%b", ctl, CTL_IDLE); n_fail++; end
    n_test++;
    if (stall_cnt !== exp_stall) begin $display("FAIL lu_stall_cnt got=%0d want=%0d", stall_cnt, exp_stall); n_fail++; end
    @(negedge clk); ex_rd = 5'd5; id_rs2 = 5'd5; ex_is_load = 1'b0; #1;
    n_test++;
    if (ctl !== CTL_IDLE) begin $display("FAIL lu_not_load got=%b want=%b", ctl, CTL_IDLE); n_fail++; end
  endtask

  task automatic test_branch();
    @(negedge clk); idle_inputs(); set_load_use(); br_taken = 1'b1; #1;
    n_test++;
    if (ctl !== CTL_BR) begin $display("FAIL br_over_lu got=%b want=%b", ctl, CTL_BR); n_fail++; end
    @(negedge clk); #1;
    n_test++;
    if (ctl !== CTL_FLU) begin $display("FAIL flush_lu got=%b want=%b", ctl, CTL_FLU); n_fail++; end
    exp_stall = exp_stall + 16'd1;
    @(negedge clk); idle_inputs(); #1;
    n_test++;
    if (ctl !== CTL_FL) begin $display("FAIL flush_last got=%b want=%b", ctl, CTL_FL); n_fail++; end
    @(negedge clk); #1;
    n_test++;
    if (ctl !== CTL_IDLE) begin $display("FAIL flush_br_ignored got=%b want=%b", ctl, CTL_IDLE); n_fail++; end
    @(negedge clk); br_taken = 1'b1; #1;
    n_test++;
    if (ctl !== CTL_BR) begin $display("FAIL br3_c0 got=%b want=%b", ctl, CTL_BR); n_fail++; end
    for (int i = 1; i < 3; i++) begin
      @(negedge clk); br_taken = 1'b0; #1;
      n_test++;
      if (ctl !== CTL_FL) begin $display("FAIL br3_c%0d got=%b want=%b", i, ctl, CTL_FL); n_fail++; end
    end
    @(negedge clk); #1;
    n_test++;
    if (ctl !== CTL_IDLE) begin $display("FAIL br3_end got=%b want=%b", ctl, CTL_IDLE); n_fail++; end
    n_test++;
    if (stall_cnt !== exp_stall) begin $display("FAIL br_stall_cnt got=%0d want=%0d", stall_cnt, exp_stall); n_fail++; end
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); idle_inputs(); mem_req = 1'b1; #1;
      n_test++;
      if (ctl !== CTL_MEM) begin $display("FAIL memwait_c%0d got=%b want=%b", i, ctl, CTL_MEM); n_fail++; end
      exp_stall = exp_stall + 16'd1;
    end
    @(negedge clk); mem_ack = 1'b1; #1;
    n_test++;
    if (ctl !== CTL_IDLE) begin $display("FAIL memwait_ack got=%b want=%b", ctl, CTL_IDLE); n_fail++; end
    @(negedge clk); idle_inputs(); #1;
    n_test++;
    if (ctl !== CTL_IDLE) begin $display("FAIL memwait_after got=%b want=%b", ctl, CTL_IDLE); n_fail++; end
    n_test++;
    if (stall_cnt !== exp_stall || mem_timeout_err !== 1'b0) begin
      $display("FAIL memwait_cnt got=%0d/%b want=%0d/0", stall_cnt, mem_timeout_err, exp_stall); n_fail++;
    end
  endtask

  task automatic test_flush_interrupt();
    @(negedge clk); idle_inputs(); br_taken = 1'b1; #1;
    n_test++;
    if (ctl !== CTL_BR) begin $display("FAIL fi_br got=%b want=%b", ctl, CTL_BR); n_fail++; end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); br_taken = 1'b0; mem_req = 1'b1; #1;
      n_test++;
      if (ctl !== CTL_MEM) begin $display("FAIL fi_wait%0d got=%b want=%b", i, ctl, CTL_MEM); n_fail++; end
      exp_stall = exp_stall + 16'd1;
    end
    @(negedge clk); mem_ack = 1'b1; #1;
    n_test++;
    if (ctl !== CTL_IDLE) begin $display("FAIL fi_ack got=%b want=%b", ctl, CTL_IDLE); n_fail++; end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); idle_inputs(); #1;
      n_test++;
      if (ctl !== CTL_FL) begin $display("FAIL fi_resume%0d got=%b want=%b", i, ctl, CTL_FL); n_fail++; end
    end
    @(negedge clk); #1;
    n_test++;
    if (ctl !== CTL_IDLE) begin $display("FAIL fi_end got=%b want=%b", ctl, CTL_IDLE); n_fail++; end
    n_test++;
    if (stall_cnt !== exp_stall) begin $display("FAIL fi_stall_cnt got=%0d want=%0d", stall_cnt, exp_stall); n_fail++; end
  endtask

  task automatic test_timeout();
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk); idle_inputs(); mem_req = 1'b1; #1;
      n_test++;
      if (ctl !== CTL_MEM || mem_timeout_err !== 1'b0) begin
        $display("FAIL to_pre%0d got=%b/%b want=%b/0", i, ctl, mem_timeout_err, CTL_MEM); n_fail++;
      end
    end
    for (int i = 9; i < 13; i++) begin
      @(negedge clk); #1;
      n_test++;
      if (ctl !== CTL_MEM || mem_timeout_err !== 1'b1) begin
        $display("FAIL to_err%0d got=%b/%b want=%b/1", i, ctl, mem_timeout_err, CTL_MEM); n_fail++;
      end
    end
    @(negedge clk); reset = 1'b1; #1;
    n_test++;
    if (ctl !== CTL_RST) begin $display("FAIL to_reset_ctl got=%b want=%b", ctl, CTL_RST); n_fail++; end
    @(negedge clk); #1;
    n_test++;
    if (mem_timeout_err !== 1'b0 || stall_cnt !== 16'd0) begin
      $display("FAIL to_reset_clr got=%b/%0d want=0/0", mem_timeout_err, stall_cnt); n_fail++;
    end
    @(negedge clk); reset = 1'b0; idle_inputs(); set_load_use(); #1;
    n_test++;
    if (ctl !== CTL_LU) begin $display("FAIL to_post_run got=%b want=%b", ctl, CTL_LU); n_fail++; end
    exp_stall = 16'd1;
  endtask

  task automatic test_reset_abort_flush();
    @(negedge clk); idle_inputs(); br_taken = 1'b1; #1;
    n_test++;
    if (ctl !== CTL_BR) begin $display("FAIL ra_br got=%b want=%b", ctl, CTL_BR); n_fail++; end
    @(negedge clk); br_taken = 1'b0; reset = 1'b1; #1;
    n_test++;
    if (ctl !== CTL_RST) begin $display("FAIL ra_reset got=%b want=%b", ctl, CTL_RST); n_fail++; end
    @(negedge clk); reset = 1'b0; #1;
    n_test++;
    if (ctl !== CTL_IDLE) begin $display("FAIL ra_run got=%b want=%b", ctl, CTL_IDLE); n_fail++; end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_flush_interrupt();
    test_timeout();
    test_reset_abort_flush();
    $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
    $finish;
  end

endmodule
